// File: rtl/mem_bus_pkg.sv
// Shared widths, FSM state encoding and the buffered request record for mem_bus_master.
package mem_bus_pkg;

    localparam int ADDR_W         = 12;
    localparam int DATA_W         = 16;
    localparam int FIFO_DEPTH_DEF = 2;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR,
        TURN
    } bus_state_t;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    localparam int REQ_W = $bits(mem_req_t);

endpackage

// File: rtl/mem_bus_master_if.sv
// CPU-side request/response handshake of mem_bus_master.
interface mem_bus_master_if;

    logic                           req_valid;
    logic                           req_ready;
    logic                           req_write;
    logic [mem_bus_pkg::ADDR_W-1:0] req_addr;
    logic [mem_bus_pkg::DATA_W-1:0] req_wdata;
    logic                           rsp_valid;
    logic [mem_bus_pkg::DATA_W-1:0] rsp_rdata;
    logic                           wr_done;

    // CPU side: issues requests, receives responses
    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, wr_done
    );

    // Bus master block: accepts requests, returns responses
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, wr_done
    );

endinterface

// File: rtl/mem_req_fifo.sv
// Request buffer for mem_bus_master: DEPTH entries of WIDTH bits, head visible without a pop.
module mem_req_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 29
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_W'(DEPTH));
    // full is judged on the pre-pop count, so a push is never taken while full
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem_reg[rd_ptr_reg];

    // DEPTH is a power of two, so pointer overflow is the wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

endmodule

// File: rtl/mem_bus_master.sv
// mem_bus_master: buffers CPU requests and plays them in order onto a strobed memory bus.
// Define MEM_BUS_TURNAROUND_EN to insert one dead TURN cycle between a read and a following write.
module mem_bus_master
    import mem_bus_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_bus_master_if.slave   cpu,
    output logic [ADDR_W-1:0] add_line,
    inout  wire  [DATA_W-1:0] data_line,
    output logic              r_line,
    output logic              w_line
);

    logic [1:0]        rst_sync_reg;
    logic              rst_n_int;

    bus_state_t        state_reg;
    logic              r_line_reg;
    logic              w_line_reg;
    logic [ADDR_W-1:0] add_line_reg;
    logic              drive_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic              rsp_valid_reg;
    logic [DATA_W-1:0] rsp_rdata_reg;
    logic              wr_done_reg;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_empty;
    logic              fifo_full;
    logic [REQ_W-1:0]  fifo_head;
    mem_req_t          head_req;

    // Assertion reaches every flop at once; release is delayed two edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_reg <= '0;
        end else begin
            rst_sync_reg <= {rst_sync_reg[0], 1'b1};
        end
    end

    assign rst_n_int = rst_sync_reg[1];

    assign cpu.req_ready = !fifo_full;
    assign fifo_push     = cpu.req_valid && !fifo_full;
    assign fifo_pop      = (state_reg == IDLE) && !fifo_empty;
    assign head_req      = mem_req_t'(fifo_head);

    mem_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (REQ_W)
    ) u_req_fifo (
        .clk       (clk),
        .rst_n     (rst_n_int),
        .push      (fifo_push),
        .push_data ({cpu.req_write, cpu.req_addr, cpu.req_wdata}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_reg     <= IDLE;
            r_line_reg    <= 1'b0;
            w_line_reg    <= 1'b0;
            add_line_reg  <= '0;
            drive_reg     <= 1'b0;
            wdata_reg     <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            wr_done_reg   <= 1'b0;
        end else begin
            rsp_valid_reg <= 1'b0;
            wr_done_reg   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (!fifo_empty) begin
                        add_line_reg <= head_req.addr;
                        if (head_req.write) begin
                            state_reg  <= WR;
                            w_line_reg <= 1'b1;
                            drive_reg  <= 1'b1;
                            wdata_reg  <= head_req.wdata;
                        end else begin
                            state_reg  <= RD_ADDR;
                            r_line_reg <= 1'b1;
                        end
                    end
                end
                RD_ADDR: begin
                    state_reg <= RD_DATA;
                end
                RD_DATA: begin
                    r_line_reg    <= 1'b0;
                    rsp_rdata_reg <= data_line;
                    rsp_valid_reg <= 1'b1;
`ifdef MEM_BUS_TURNAROUND_EN
                    // head is the request behind the read that just finished
                    state_reg <= (!fifo_empty && head_req.write) ? TURN : IDLE;
`else
                    state_reg <= IDLE;
`endif
                end
                WR: begin
                    w_line_reg  <= 1'b0;
                    drive_reg   <= 1'b0;
                    wr_done_reg <= 1'b1;
                    state_reg   <= IDLE;
                end
                TURN: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign data_line     = drive_reg ? wdata_reg : 'z;
    assign add_line      = add_line_reg;
    assign r_line        = r_line_reg;
    assign w_line        = w_line_reg;
    assign cpu.rsp_valid = rsp_valid_reg;
    assign cpu.rsp_rdata = rsp_rdata_reg;
    assign cpu.wr_done   = wr_done_reg;

endmodule

// File: tb/tb_mem_bus_master.sv
// Randomised bench for mem_bus_master: a request log plus a word-array memory model
// predicts every bus cycle, response and ready level.
module tb_mem_bus_master;
    import mem_bus_pkg::*;

`ifdef MEM_BUS_TURNAROUND_EN
    localparam int RW_SPAN = 5;
`else
    localparam int RW_SPAN = 4;
`endif

    logic              clk;
    logic              rst_n;
    wire  [DATA_W-1:0] data_line;
    logic [ADDR_W-1:0] add_line;
    logic              r_line;
    logic              w_line;

    mem_bus_master_if cpu ();

    mem_bus_master #(
        .FIFO_DEPTH (FIFO_DEPTH_DEF)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu       (cpu),
        .add_line  (add_line),
        .data_line (data_line),
        .r_line    (r_line),
        .w_line    (w_line)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // environment memory answering the strobes, and the reference memory
    logic [DATA_W-1:0] bus_mem   [4096];
    logic [DATA_W-1:0] model_mem [4096];
    mem_req_t          req_log   [256];
    int                acc_cnt = 0;
    int                started = 0;
    int                cyc = 0;
    int                rd_start_cyc = 0;
    int                wr_cyc = 0;

    function automatic logic [DATA_W-1:0] mem_init(input int i);
        return DATA_W'(i * 291) ^ 16'h5A5A;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    assign data_line = r_line ? bus_mem[add_line] : 'z;

    initial begin
        for (int i = 0; i < 4096; i++) bus_mem[i] = mem_init(i);
        forever begin
            @(negedge clk);
            if (w_line) bus_mem[add_line] = data_line;
        end
    end

    // monitor: samples just after each rising edge
    initial begin
        logic              prev_r;
        logic              prev_w;
        logic              rsp_exp;
        int                r_run;
        logic [ADDR_W-1:0] last_addr;
        logic [DATA_W-1:0] exp_rdata;
        logic [DATA_W-1:0] hold_rdata;
        mem_req_t          op;
        prev_r = 1'b0; prev_w = 1'b0; r_run = 0;
        last_addr = '0; exp_rdata = '0; hold_rdata = '0;
        for (int i = 0; i < 4096; i++) model_mem[i] = mem_init(i);
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!rst_n) begin
                started = 0; prev_r = 1'b0; prev_w = 1'b0; r_run = 0;
                last_addr = '0; hold_rdata = '0;
            end else begin
                rsp_exp = prev_r && !r_line;
                chk("no_overlap", 32'(r_line & w_line), 0);
                chk("wr_len", 32'(prev_w & w_line), 0);
                chk("rsp_valid", 32'(cpu.rsp_valid), 32'(rsp_exp));
                if (rsp_exp) begin
                    chk("rd_len", 32'(r_run), 2);
                    hold_rdata = exp_rdata;
                end
                chk("rsp_rdata", 32'(cpu.rsp_rdata), 32'(hold_rdata));
                chk("wr_done", 32'(cpu.wr_done), 32'(prev_w));
                if ((r_line && !prev_r) || w_line) begin
                    if (started >= acc_cnt) begin
                        chk("unexpected_op", 1, 0);
                    end else begin
                        op = req_log[started];
                        started++;
                        chk("op_kind", 32'(op.write), 32'(w_line));
                        chk("op_addr", 32'(add_line), 32'(op.addr));
                        last_addr = op.addr;
                        if (w_line) begin
                            chk("wr_data", 32'(data_line), 32'(op.wdata));
                            model_mem[op.addr] = op.wdata;
                            wr_cyc = cyc;
                        end else begin
                            exp_rdata = model_mem[op.addr];
                            rd_start_cyc = cyc;
                        end
                    end
                end else begin
                    chk("addr_hold", 32'(add_line), 32'(last_addr));
                end
                chk("req_ready", 32'(cpu.req_ready), 32'((acc_cnt - started) < FIFO_DEPTH_DEF));
                if (r_line) r_run = prev_r ? r_run + 1 : 1;
                prev_r = r_line;
                prev_w = w_line;
            end
        end
    end

    task automatic send(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        int t;
        cpu.req_valid = 1'b1;
        cpu.req_write = wr;
        cpu.req_addr  = a;
        cpu.req_wdata = d;
        t = 0;
        while (!cpu.req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("ready_wait", 32'(cpu.req_ready), 1);
        if (cpu.req_ready) begin
            req_log[acc_cnt] = '{write: wr, addr: a, wdata: d};
            acc_cnt++;
            $display("req %0d %s addr=%03h wdata=%04h", acc_cnt, wr ? "WR" : "RD", a, d);
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((started != acc_cnt || r_line || w_line) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain", 32'(t < 200), 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int t;
        rst_n = 1'b0;
        cpu.req_valid = 1'b0;
        cpu.req_write = 1'b0;
        cpu.req_addr  = '0;
        cpu.req_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_r_line", 32'(r_line), 0);
        chk("rst_w_line", 32'(w_line), 0);
        chk("rst_add_line", 32'(add_line), 0);
        chk("rst_rsp_valid", 32'(cpu.rsp_valid), 0);
        chk("rst_wr_done", 32'(cpu.wr_done), 0);
        chk("rst_rsp_rdata", 32'(cpu.rsp_rdata), 0);
        chk("rst_req_ready", 32'(cpu.req_ready), 1);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        send(1'b1, 12'h010, 16'hBEEF);
        cpu.req_valid = 1'b0;
        drain();
        chk("bus_mem_010", 32'(bus_mem[12'h010]), 32'h0000_BEEF);

        send(1'b0, 12'h010, 16'h0000);
        cpu.req_valid = 1'b0;
        drain();
        chk("rd_010", 32'(cpu.rsp_rdata), 32'h0000_BEEF);

        // three back-to-back with valid held high
        send(1'b1, 12'h100, 16'h1111);
        send(1'b0, 12'h010, 16'h0000);
        send(1'b0, 12'h100, 16'h0000);
        chk("ready_full", 32'(cpu.req_ready), 0);
        cpu.req_valid = 1'b0;
        drain();
        chk("b2b_last", 32'(cpu.rsp_rdata), 32'h0000_1111);

        send(1'b0, 12'h001, 16'h0000);
        send(1'b1, 12'h002, 16'h2222);
        cpu.req_valid = 1'b0;
        drain();
        chk("rw_span", 32'(wr_cyc - rd_start_cyc + 1), RW_SPAN);

        send(1'b1, 12'hFFF, 16'h0001);
        send(1'b0, 12'hFFF, 16'h0000);
        cpu.req_valid = 1'b0;
        drain();
        chk("rd_fff", 32'(cpu.rsp_rdata), 32'h0000_0001);

        for (int n = 0; n < 40; n++) begin
            int gap;
            gap = $urandom_range(0, 2);
            if (gap != 0) begin
                cpu.req_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
            send(1'($urandom_range(0, 1)), 12'($urandom_range(0, 7)), 16'($urandom));
        end
        cpu.req_valid = 1'b0;
        drain();

        // reset while a read sits in RD_DATA with a write buffered behind it
        send(1'b0, 12'h010, 16'h0000);
        cpu.req_valid = 1'b0;
        t = 0;
        while (!r_line && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("rd_started", 32'(r_line), 1);
        send(1'b1, 12'h030, 16'h3333);
        cpu.req_valid = 1'b0;
        chk("in_rd_data", 32'(r_line), 1);
        #2;
        rst_n = 1'b0;
        acc_cnt = 0;
        #1;
        chk("abort_r_line", 32'(r_line), 0);
        chk("abort_w_line", 32'(w_line), 0);
        chk("abort_add_line", 32'(add_line), 0);
        chk("abort_rsp_valid", 32'(cpu.rsp_valid), 0);
        chk("abort_req_ready", 32'(cpu.req_ready), 1);
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_rsp", 32'(cpu.rsp_valid), 0);
        end
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            chk("abort_discard", 32'(r_line | w_line), 0);
        end
        send(1'b0, 12'h010, 16'h0000);
        cpu.req_valid = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
